// File: rtl/serial_init_port.sv
// Initiator-side serial bus port: arbitrates for the bus, serializes address and write
// data LSB first, and assembles (possibly split) serial read data for the core.
module serial_init_port #(
   parameter int ADDR_WIDTH = 16,
   parameter int DATA_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  init_req,
   input  logic                  arbiter_grant,
   input  logic [DATA_WIDTH-1:0] init_data_out,
   input  logic                  init_data_out_valid,
   input  logic [ADDR_WIDTH-1:0] init_addr_out,
   input  logic                  init_addr_out_valid,
   input  logic                  init_rw,
   input  logic                  init_ready,
   input  logic                  target_split,
   input  logic                  target_ack,
   input  logic                  bus_data_in_valid,
   input  logic                  bus_data_in,
   output logic                  bus_data_out,
   output logic                  init_grant,
   output logic [DATA_WIDTH-1:0] init_data_in,
   output logic                  init_data_in_valid,
   output logic                  bus_data_out_valid,
   output logic                  arbiter_req,
   output logic                  bus_mode,
   output logic                  init_ack,
   output logic                  bus_init_ready,
   output logic                  bus_init_rw,
   output logic                  init_split_ack
);

   localparam logic [2:0] IDLE       = 3'd0;
   localparam logic [2:0] REQ        = 3'd1;
   localparam logic [2:0] LATCH      = 3'd2;
   localparam logic [2:0] ADDR       = 3'd3;
   localparam logic [2:0] WDATA      = 3'd4;
   localparam logic [2:0] WAIT_ACK   = 3'd5;
   localparam logic [2:0] RDATA      = 3'd6;
   localparam logic [2:0] SPLIT_WAIT = 3'd7;

   localparam int MAX_W = (ADDR_WIDTH > DATA_WIDTH) ? ADDR_WIDTH : DATA_WIDTH;
   localparam int CNT_W = $clog2(MAX_W + 1);
   localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
   localparam logic [CNT_W-1:0] ADDR_LAST = CNT_W'(ADDR_WIDTH);
   localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_WIDTH);
   localparam logic [CNT_W-1:0] RD_LAST   = CNT_W'(DATA_WIDTH - 1);

   logic [2:0]            state_r, state_s;
   logic [ADDR_WIDTH-1:0] addr_sh_r, addr_sh_s;
   logic [DATA_WIDTH-1:0] data_sh_r, data_sh_s;
   logic [DATA_WIDTH-1:0] rd_sh_r, rd_sh_s, rd_shift_s;
   logic [CNT_W-1:0]      bit_cnt_r, bit_cnt_s;
   logic [CNT_W-1:0]      rd_cnt_r, rd_cnt_s;
   logic                  rd_last_s;
   logic                  ack_pend_r, ack_pend_s;
   logic                  arbiter_req_r, arbiter_req_s;
   logic                  init_grant_r, init_grant_s;
   logic                  bus_init_rw_r, bus_init_rw_s;
   logic                  bus_init_ready_r, bus_init_ready_s;
   logic [DATA_WIDTH-1:0] init_data_in_r, init_data_in_s;
   logic                  init_data_in_valid_r, init_data_in_valid_s;
   logic                  init_ack_r, init_ack_s;
   logic                  init_split_ack_r, init_split_ack_s;
   logic                  bus_data_out_r, bus_data_out_s;
   logic                  bus_data_out_valid_r, bus_data_out_valid_s;
   logic                  bus_mode_r, bus_mode_s;

   // Next-state and next-output computation; every output is registered from these values.
   always_comb begin
      state_s              = state_r;
      addr_sh_s            = addr_sh_r;
      data_sh_s            = data_sh_r;
      rd_sh_s              = rd_sh_r;
      bit_cnt_s            = bit_cnt_r;
      rd_cnt_s             = rd_cnt_r;
      ack_pend_s           = ack_pend_r;
      arbiter_req_s        = arbiter_req_r;
      init_grant_s         = init_grant_r;
      bus_init_rw_s        = bus_init_rw_r;
      init_data_in_s       = init_data_in_r;
      init_data_in_valid_s = 1'b0;
      init_ack_s           = 1'b0;
      init_split_ack_s     = 1'b0;
      bus_data_out_s       = 1'b0;
      bus_data_out_valid_s = 1'b0;
      bus_mode_s           = 1'b0;
      rd_shift_s           = {bus_data_in, rd_sh_r[DATA_WIDTH-1:1]};
      rd_last_s            = bus_data_in_valid & (rd_cnt_r == RD_LAST);

      case (state_r)
         IDLE: begin
            init_grant_s  = 1'b0;
            bus_init_rw_s = 1'b0;
            if (init_req) begin
               arbiter_req_s = 1'b1;
               state_s       = REQ;
            end else begin
               arbiter_req_s = 1'b0;
            end
         end
         REQ: begin
            arbiter_req_s = 1'b1;
            if (arbiter_grant) begin
               init_grant_s = 1'b1;
               state_s      = LATCH;
            end else begin
               init_grant_s = 1'b0;
            end
         end
         LATCH: begin
            // Address bit 0 is presented straight from the core so ADDR starts next cycle.
            if (init_addr_out_valid && (!init_rw || init_data_out_valid)) begin
               bus_init_rw_s        = init_rw;
               addr_sh_s            = {1'b0, init_addr_out[ADDR_WIDTH-1:1]};
               data_sh_s            = init_data_out;
               bus_data_out_s       = init_addr_out[0];
               bus_data_out_valid_s = 1'b1;
               bus_mode_s           = 1'b1;
               bit_cnt_s            = CNT_ONE;
               rd_cnt_s             = CNT_ZERO;
               ack_pend_s           = 1'b0;
               state_s              = ADDR;
            end else begin
               state_s = LATCH;
            end
         end
         ADDR: begin
            if (bit_cnt_r != ADDR_LAST) begin
               bus_data_out_s       = addr_sh_r[0];
               addr_sh_s            = {1'b0, addr_sh_r[ADDR_WIDTH-1:1]};
               bus_data_out_valid_s = 1'b1;
               bus_mode_s           = 1'b1;
               bit_cnt_s            = bit_cnt_r + CNT_ONE;
            end else if (bus_init_rw_r) begin
               bus_data_out_s       = data_sh_r[0];
               data_sh_s            = {1'b0, data_sh_r[DATA_WIDTH-1:1]};
               bus_data_out_valid_s = 1'b1;
               bit_cnt_s            = CNT_ONE;
               state_s              = WDATA;
            end else begin
               bit_cnt_s = CNT_ZERO;
               state_s   = RDATA;
            end
         end
         WDATA: begin
            if (bit_cnt_r != DATA_LAST) begin
               bus_data_out_s       = data_sh_r[0];
               data_sh_s            = {1'b0, data_sh_r[DATA_WIDTH-1:1]};
               bus_data_out_valid_s = 1'b1;
               bit_cnt_s            = bit_cnt_r + CNT_ONE;
            end else begin
               bit_cnt_s = CNT_ZERO;
               state_s   = WAIT_ACK;
            end
         end
         WAIT_ACK: begin
            // ack_pend_r carries an ack that coincided with the final read bit.
            if (target_ack || ack_pend_r) begin
               init_ack_s    = 1'b1;
               arbiter_req_s = 1'b0;
               init_grant_s  = 1'b0;
               ack_pend_s    = 1'b0;
               bus_init_rw_s = 1'b0;
               state_s       = IDLE;
            end else begin
               state_s = WAIT_ACK;
            end
         end
         RDATA: begin
            if (bus_data_in_valid) begin
               rd_sh_s  = rd_shift_s;
               rd_cnt_s = rd_cnt_r + CNT_ONE;
            end else begin
               rd_sh_s = rd_sh_r;
            end
            if (rd_last_s) begin
               init_data_in_s       = rd_shift_s;
               init_data_in_valid_s = 1'b1;
               rd_cnt_s             = CNT_ZERO;
               ack_pend_s           = target_ack;
               state_s              = WAIT_ACK;
            end else if (target_split) begin
               init_split_ack_s = 1'b1;
               arbiter_req_s    = 1'b0;
               init_grant_s     = 1'b0;
               state_s          = SPLIT_WAIT;
            end else begin
               state_s = RDATA;
            end
         end
         SPLIT_WAIT: begin
            // Grants here belong to the split target; only the remaining read bits matter.
            if (bus_data_in_valid) begin
               rd_sh_s  = rd_shift_s;
               rd_cnt_s = rd_cnt_r + CNT_ONE;
            end else begin
               rd_sh_s = rd_sh_r;
            end
            if (rd_last_s) begin
               init_data_in_s       = rd_shift_s;
               init_data_in_valid_s = 1'b1;
               rd_cnt_s             = CNT_ZERO;
               ack_pend_s           = target_ack;
               state_s              = WAIT_ACK;
            end else begin
               state_s = SPLIT_WAIT;
            end
         end
         default: begin
            arbiter_req_s = 1'b0;
            init_grant_s  = 1'b0;
            state_s       = IDLE;
         end
      endcase

      bus_init_ready_s = (state_s != IDLE) ? init_ready : 1'b0;
   end

   // State, datapath and output registers; async reset abandons any transaction in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r              <= IDLE;
         addr_sh_r            <= {ADDR_WIDTH{1'b0}};
         data_sh_r            <= {DATA_WIDTH{1'b0}};
         rd_sh_r              <= {DATA_WIDTH{1'b0}};
         bit_cnt_r            <= CNT_ZERO;
         rd_cnt_r             <= CNT_ZERO;
         ack_pend_r           <= 1'b0;
         arbiter_req_r        <= 1'b0;
         init_grant_r         <= 1'b0;
         bus_init_rw_r        <= 1'b0;
         bus_init_ready_r     <= 1'b0;
         init_data_in_r       <= {DATA_WIDTH{1'b0}};
         init_data_in_valid_r <= 1'b0;
         init_ack_r           <= 1'b0;
         init_split_ack_r     <= 1'b0;
         bus_data_out_r       <= 1'b0;
         bus_data_out_valid_r <= 1'b0;
         bus_mode_r           <= 1'b0;
      end else begin
         state_r              <= state_s;
         addr_sh_r            <= addr_sh_s;
         data_sh_r            <= data_sh_s;
         rd_sh_r              <= rd_sh_s;
         bit_cnt_r            <= bit_cnt_s;
         rd_cnt_r             <= rd_cnt_s;
         ack_pend_r           <= ack_pend_s;
         arbiter_req_r        <= arbiter_req_s;
         init_grant_r         <= init_grant_s;
         bus_init_rw_r        <= bus_init_rw_s;
         bus_init_ready_r     <= bus_init_ready_s;
         init_data_in_r       <= init_data_in_s;
         init_data_in_valid_r <= init_data_in_valid_s;
         init_ack_r           <= init_ack_s;
         init_split_ack_r     <= init_split_ack_s;
         bus_data_out_r       <= bus_data_out_s;
         bus_data_out_valid_r <= bus_data_out_valid_s;
         bus_mode_r           <= bus_mode_s;
      end
   end

   assign bus_data_out       = bus_data_out_r;
   assign init_grant         = init_grant_r;
   assign init_data_in       = init_data_in_r;
   assign init_data_in_valid = init_data_in_valid_r;
   assign bus_data_out_valid = bus_data_out_valid_r;
   assign arbiter_req        = arbiter_req_r;
   assign bus_mode           = bus_mode_r;
   assign init_ack           = init_ack_r;
   assign bus_init_ready     = bus_init_ready_r;
   assign bus_init_rw        = bus_init_rw_r;
   assign init_split_ack     = init_split_ack_r;

endmodule

// File: tb/tb_serial_init_port.sv
// Scoreboard bench for serial_init_port: stimulus queues expected bus bits and core
// events, an independent negedge monitor pops and compares them as the DUT emits them.
module tb_serial_init_port;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       init_req, arbiter_grant, init_data_out_valid, init_addr_out_valid;
   logic       init_rw, init_ready, target_split, target_ack;
   logic       bus_data_in_valid, bus_data_in;
   logic [7:0] init_data_out;
   logic [15:0] init_addr_out;
   logic       bus_data_out, init_grant, init_data_in_valid, bus_data_out_valid;
   logic       arbiter_req, bus_mode, init_ack, bus_init_ready, bus_init_rw, init_split_ack;
   logic [7:0] init_data_in;

   int n_checks = 0;
   int n_fail   = 0;
   int bits_total = 0;

   // bit queue entries are {bus_mode, bus_data_out}; event entries are {kind, value}
   // with kind 0 = read data, 1 = split ack, 2 = transaction ack
   logic [1:0] bit_q[$];
   logic [9:0] ev_q[$];

   serial_init_port #(.ADDR_WIDTH(16), .DATA_WIDTH(8)) dut (
      .clk(clk), .rst_n(rst_n), .init_req(init_req), .arbiter_grant(arbiter_grant),
      .init_data_out(init_data_out), .init_data_out_valid(init_data_out_valid),
      .init_addr_out(init_addr_out), .init_addr_out_valid(init_addr_out_valid),
      .init_rw(init_rw), .init_ready(init_ready), .target_split(target_split),
      .target_ack(target_ack), .bus_data_in_valid(bus_data_in_valid), .bus_data_in(bus_data_in),
      .bus_data_out(bus_data_out), .init_grant(init_grant), .init_data_in(init_data_in),
      .init_data_in_valid(init_data_in_valid), .bus_data_out_valid(bus_data_out_valid),
      .arbiter_req(arbiter_req), .bus_mode(bus_mode), .init_ack(init_ack),
      .bus_init_ready(bus_init_ready), .bus_init_rw(bus_init_rw), .init_split_ack(init_split_ack)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [17:0] all_outs();
      return {bus_data_out, init_grant, init_data_in, init_data_in_valid, bus_data_out_valid,
              arbiter_req, bus_mode, init_ack, bus_init_ready, bus_init_rw, init_split_ack};
   endfunction

   // Monitor: every presented output is checked against the next queued expectation.
   always @(negedge clk) begin
      if (bus_data_out_valid) begin
         bits_total++;
         if (bit_q.size() == 0) chk("unexpected_bus_bit", {30'd0, bus_mode, bus_data_out}, 32'hFFFF);
         else chk("bus_bit", {30'd0, bus_mode, bus_data_out}, {30'd0, bit_q.pop_front()});
      end
      if (init_data_in_valid) begin
         if (ev_q.size() == 0) chk("unexpected_rdata", {22'd0, 2'd0, init_data_in}, 32'hFFFF);
         else chk("rdata_event", {22'd0, 2'd0, init_data_in}, {22'd0, ev_q.pop_front()});
      end
      if (init_split_ack) begin
         if (ev_q.size() == 0) chk("unexpected_split_ack", 32'h100, 32'hFFFF);
         else chk("split_event", 32'h100, {22'd0, ev_q.pop_front()});
      end
      if (init_ack) begin
         if (ev_q.size() == 0) chk("unexpected_init_ack", 32'h200, 32'hFFFF);
         else chk("ack_event", 32'h200, {22'd0, ev_q.pop_front()});
      end
   end

   task automatic send_read(input logic [7:0] rdata, input bit gaps, input bit ack_last);
      for (int i = 0; i < 8; i++) begin
         if (gaps && (i % 3 == 1)) begin
            bus_data_in_valid = 1'b0;
            target_ack = 1'b0;
            tick();
         end
         bus_data_in_valid = 1'b1;
         bus_data_in = rdata[i];
         target_ack = ack_last && (i == 7);
         tick();
      end
      bus_data_in_valid = 1'b0;
      bus_data_in = 1'b0;
      target_ack = 1'b0;
   endtask

   task automatic run_txn(input logic [15:0] addr, input logic [7:0] wdata, input logic rw,
                          input int grant_delay, input bit split, input logic [7:0] rdata,
                          input bit ack_last, input int abort_after, input bit wr_stray_split);
      int base;
      int nbits;
      int c;
      nbits = rw ? 24 : 16;
      for (int i = 0; i < 16; i++) bit_q.push_back({1'b1, addr[i]});
      if (rw) for (int i = 0; i < 8; i++) bit_q.push_back({1'b0, wdata[i]});
      base = bits_total;
      arbiter_grant = 1'b0;
      init_req = 1'b1;
      init_addr_out = addr;
      init_addr_out_valid = 1'b1;
      init_data_out = wdata;
      init_data_out_valid = rw;
      init_rw = rw;
      tick();
      repeat (grant_delay) tick();
      chk("no_bits_before_grant", bits_total - base, 32'd0);
      chk("req_held_no_grant", {30'd0, arbiter_req, init_grant}, 32'h2);
      arbiter_grant = 1'b1;
      tick();
      init_req = 1'b0;
      chk("grant_cycle", {30'd0, init_grant, bus_data_out_valid}, 32'h2);
      tick();
      chk("first_addr_bit", {28'd0, bus_data_out_valid, bus_mode, bus_init_rw, bus_init_ready},
          {28'd0, 1'b1, 1'b1, rw, 1'b1});
      c = 0;
      while ((bits_total - base < nbits) && (c < 200)) begin
         if (abort_after >= 0 && (bits_total - base == abort_after)) begin
            #1 rst_n = 1'b0;
            #1 chk("outputs_zero_on_async_reset", {14'd0, all_outs()}, 32'd0);
            bit_q.delete();
            init_req = 1'b0; init_addr_out_valid = 1'b0; init_data_out_valid = 1'b0;
            arbiter_grant = 1'b0;
            tick();
            rst_n = 1'b1;
            repeat (3) tick();
            chk("no_ack_after_abort", {31'd0, init_ack}, 32'd0);
            return;
         end
         target_split = wr_stray_split && (bits_total - base == 20);
         tick();
         c++;
      end
      target_split = 1'b0;
      if (bits_total - base < nbits) chk("bus_bits_timeout", bits_total - base, nbits);
      init_addr_out_valid = 1'b0;
      init_data_out_valid = 1'b0;
      if (rw) begin
         ev_q.push_back(10'h200);
         target_ack = 1'b1;
         tick();
         target_ack = 1'b0;
         chk("req_grant_drop_after_ack", {29'd0, init_ack, arbiter_req, init_grant}, 32'h4);
      end else begin
         if (split) begin
            ev_q.push_back(10'h100);
            target_split = 1'b1;
            tick();
            target_split = 1'b0;
            chk("split_drops_req", {29'd0, init_split_ack, arbiter_req, init_grant}, 32'h4);
            repeat (3) tick();
         end
         ev_q.push_back({2'd0, rdata});
         ev_q.push_back(10'h200);
         send_read(rdata, split, ack_last);
         chk("rdata_valid", {23'd0, init_data_in_valid, init_data_in}, {23'd0, 1'b1, rdata});
         chk("ack_not_with_data", {31'd0, init_ack}, 32'd0);
         if (!ack_last) begin
            target_ack = 1'b1;
            tick();
            target_ack = 1'b0;
         end else begin
            tick();
         end
         chk("ack_after_read", {30'd0, init_ack, arbiter_req}, 32'h2);
      end
      tick();
      tick();
   endtask

   initial begin
      rst_n = 1'b0;
      init_req = 1'b0; arbiter_grant = 1'b0; init_data_out = 8'h00; init_data_out_valid = 1'b0;
      init_addr_out = 16'h0000; init_addr_out_valid = 1'b0; init_rw = 1'b0; init_ready = 1'b1;
      target_split = 1'b0; target_ack = 1'b0; bus_data_in_valid = 1'b0; bus_data_in = 1'b0;
      repeat (3) tick();
      chk("reset_outputs", {14'd0, all_outs()}, 32'd0);
      rst_n = 1'b1;
      tick();
      chk("idle_outputs", {14'd0, all_outs()}, 32'd0);

      target_ack = 1'b1;
      tick();
      target_ack = 1'b0;
      tick();
      chk("stray_ack_idle", {30'd0, init_ack, arbiter_req}, 32'd0);

      // write 800A/5C with grant withheld 10 cycles and a stray split in WDATA
      run_txn(16'h800A, 8'h5C, 1'b1, 10, 1'b0, 8'h00, 1'b0, -1, 1'b1);
      // split read returning 5C
      run_txn(16'h800A, 8'h00, 1'b0, 0, 1'b1, 8'h5C, 1'b0, -1, 1'b0);
      // non-split read A5 with ack coincident with the final bit
      run_txn(16'h4321, 8'h00, 1'b0, 1, 1'b0, 8'hA5, 1'b1, -1, 1'b0);
      // reset in the middle of the address phase, then a fresh write
      run_txn(16'h1234, 8'h99, 1'b1, 0, 1'b0, 8'h00, 1'b0, 5, 1'b0);
      run_txn(16'hBEEF, 8'h3C, 1'b1, 2, 1'b0, 8'h00, 1'b0, -1, 1'b0);
      run_txn(16'h0001, 8'h00, 1'b0, 0, 1'b0, 8'h81, 1'b0, -1, 1'b0);

      repeat (4) tick();
      chk("bit_queue_drained", bit_q.size(), 32'd0);
      chk("event_queue_drained", ev_q.size(), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule
